// File: rtl/lc3b_prefetch_fetch.sv
// LC-3b fetch stage with an instruction prefetch queue.
// Owns the PC, issues one word fetch at a time over a multi-cycle imem
// handshake, buffers {npc, ir} pairs in a DEPTH-entry FIFO and presents the
// FIFO head to the decode latch. A MEM-stage redirect flushes the queue,
// reloads the PC and drops any in-flight response.
module lc3b_prefetch_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dep_stall,
  input  logic                       mem_stall,
  input  logic                       v_de_br_stall,
  input  logic                       v_agex_br_stall,
  input  logic                       v_mem_br_stall,
  input  logic [1:0]                 mem_pcmux,
  input  logic [15:0]                target_pc,
  input  logic [15:0]                trap_pc,
  output logic                       imem_req,
  output logic [15:0]                imem_addr,
  input  logic                       imem_r,
  input  logic [15:0]                imem_data,
  output logic                       de_v,
  output logic [15:0]                de_npc,
  output logic [15:0]                de_ir,
  output logic                       ld_de,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DISCARD
  } state_e;

  typedef struct packed {
    logic [15:0] npc;
    logic [15:0] ir;
  } entry_t;

  state_e           state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic             post_rst_q;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  entry_t           queue_q [DEPTH];

  logic             redirect;
  logic [15:0]      redirect_pc;
  logic             br_stall;
  logic             slot_free;
  logic             push;
  logic             pop;

  // Redirect decode: only selects 1 and 2 steer the PC; bit0 is never fetched.
  always_comb begin
    redirect    = (mem_pcmux == 2'd1) || (mem_pcmux == 2'd2);
    redirect_pc = (mem_pcmux == 2'd1) ? target_pc : trap_pc;
    redirect_pc = {redirect_pc[15:1], 1'b0};
  end

  // Issue, dequeue and enqueue strobes.
  always_comb begin
    br_stall  = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
    // A request is only ever issued from FETCH, where nothing is pending, so
    // occupancy alone decides whether a slot can be reserved for it.
    slot_free = count_q < CNT_W'(DEPTH);
    imem_req  = ~reset & ~post_rst_q & (state_q == S_FETCH) & ~br_stall
              & ~redirect & slot_free;
    imem_addr = {pc_q[15:1], 1'b0};
    de_v      = ~reset & (count_q != '0);
    ld_de     = de_v & ~dep_stall & ~mem_stall & ~redirect;
    pop       = ld_de;
    push      = ~reset & (state_q == S_WAIT) & imem_r & ~redirect;
    de_npc    = queue_q[rd_ptr_q].npc;
    de_ir     = queue_q[rd_ptr_q].ir;
    q_count   = reset ? '0 : count_q;
  end

  // Next-state and PC logic; a redirect overrides any PC update.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_req) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_r) begin
          state_d = S_FETCH;
          pc_d    = pc_q + 16'd2;
        end else if (redirect) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_r) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (redirect) pc_d = redirect_pc;
  end

  // State, PC and post-reset register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      post_rst_q <= 1'b0;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue storage: writes the fetched word with its next-PC.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; occupancy and pointers alone
    // decide which entries are valid, so stale contents are never observed.
    if (push) queue_q[wr_ptr_q] <= '{npc: pc_q + 16'd2, ir: imem_data};
  end

endmodule

// File: tb/tb_lc3b_prefetch_fetch.sv
// Directed bench for lc3b_prefetch_fetch: a variable-latency imem responder
// with mem[a] = a ^ 16'hA5A5 and one task per scenario.
module tb_lc3b_prefetch_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dep_stall = 1'b0;
  logic        mem_stall = 1'b0;
  logic        v_de_br_stall = 1'b0;
  logic        v_agex_br_stall = 1'b0;
  logic        v_mem_br_stall = 1'b0;
  logic [1:0]  mem_pcmux = 2'd0;
  logic [15:0] target_pc = 16'h0;
  logic [15:0] trap_pc = 16'h0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_r = 1'b0;
  logic [15:0] imem_data = 16'h0;
  logic        de_v;
  logic [15:0] de_npc;
  logic [15:0] de_ir;
  logic        ld_de;
  logic [2:0]  q_count;

  int vecs = 0;
  int miscompares = 0;

  // Responder state.
  int          lat = 2;
  int          cnt = 0;
  logic        busy = 1'b0;
  logic [15:0] r_addr = 16'h0;
  logic        take_s;
  logic        done_s;
  logic [15:0] addr_s;

  lc3b_prefetch_fetch #(.DEPTH(4), .RESET_PC(16'h3000)) dut (
    .clk            (clk),
    .reset          (reset),
    .dep_stall      (dep_stall),
    .mem_stall      (mem_stall),
    .v_de_br_stall  (v_de_br_stall),
    .v_agex_br_stall(v_agex_br_stall),
    .v_mem_br_stall (v_mem_br_stall),
    .mem_pcmux      (mem_pcmux),
    .target_pc      (target_pc),
    .trap_pc        (trap_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_r         (imem_r),
    .imem_data      (imem_data),
    .de_v           (de_v),
    .de_npc         (de_npc),
    .de_ir          (de_ir),
    .ld_de          (ld_de),
    .q_count        (q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // imem model: responds lat cycles after the request cycle, cleared by reset.
  always @(posedge clk) begin
    take_s = imem_req && !busy && !reset;
    done_s = imem_r;
    addr_s = imem_addr;
    #1;
    if (reset || done_s) begin
      imem_r = 1'b0;
      busy   = 1'b0;
    end
    if (take_s) begin
      busy   = 1'b1;
      r_addr = addr_s;
      cnt    = lat - 1;
    end else if (busy && cnt > 0) begin
      cnt = cnt - 1;
    end
    if (busy && cnt == 0) begin
      imem_r    = 1'b1;
      imem_data = mem_word(r_addr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int latency);
    lat = latency;
    reset = 1'b1;
    dep_stall = 1'b0; mem_stall = 1'b0;
    v_de_br_stall = 1'b0; v_agex_br_stall = 1'b0; v_mem_br_stall = 1'b0;
    mem_pcmux = 2'd0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Waits (bounded) until the queue is full with issue idle.
  task automatic fill_queue(input string name);
    bit ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (q_count == 3'd4 && !imem_req) ok = 1;
      else step();
    end
    vecs++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s_fill timeout q_count=%0d exp 4", name, q_count);
    end
  endtask

  task automatic test_reset();
    int npop = 0;
    logic [15:0] exp_req = 16'h3002;
    logic [15:0] exp_pop = 16'h3000;
    lat = 2;
    reset = 1'b1;
    step();
    @(negedge clk);
    vecs++;
    if (imem_req !== 1'b0 || de_v !== 1'b0 || ld_de !== 1'b0 || q_count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_during req=%b de_v=%b ld_de=%b q=%0d exp 0,0,0,0", imem_req, de_v, ld_de, q_count);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    vecs++;
    if (imem_req !== 1'b0 || de_v !== 1'b0 || ld_de !== 1'b0 || q_count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_after req=%b de_v=%b ld_de=%b q=%0d exp 0,0,0,0", imem_req, de_v, ld_de, q_count);
    end
    step();
    @(negedge clk);
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h3000) begin
      miscompares++;
      $display("FAIL first_fetch req=%b addr=%h exp 1 3000", imem_req, imem_addr);
    end
    for (int c = 0; c < 30 && npop < 3; c++) begin
      step();
      @(negedge clk);
      if (imem_req) begin
        vecs++;
        if (imem_addr !== exp_req) begin
          miscompares++;
          $display("FAIL seq_addr got %h exp %h", imem_addr, exp_req);
        end
        exp_req += 16'd2;
      end
      if (ld_de) begin
        vecs++;
        if (de_npc !== exp_pop + 16'd2 || de_ir !== mem_word(exp_pop)) begin
          miscompares++;
          $display("FAIL seq_pop npc=%h ir=%h exp %h %h", de_npc, de_ir, exp_pop + 16'd2, mem_word(exp_pop));
        end
        exp_pop += 16'd2;
        npop++;
      end
    end
    vecs++;
    if (npop != 3) begin
      miscompares++;
      $display("FAIL seq_timeout pops=%0d exp 3", npop);
    end
  endtask

  task automatic test_fill_drain();
    int nreq = 0;
    int npop = 0;
    bit seen = 0;
    logic [15:0] exp_req = 16'h3000;
    logic [15:0] exp_pop = 16'h3000;
    do_reset(2);
    dep_stall = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (imem_req) begin
        vecs++;
        if (imem_addr !== exp_req) begin
          miscompares++;
          $display("FAIL fill_addr got %h exp %h", imem_addr, exp_req);
        end
        exp_req += 16'd2;
        nreq++;
      end
      step();
    end
    @(negedge clk);
    vecs++;
    if (nreq != 4 || q_count !== 3'd4 || imem_req !== 1'b0 || de_v !== 1'b1 || ld_de !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full nreq=%0d q=%0d req=%b de_v=%b ld_de=%b exp 4,4,0,1,0", nreq, q_count, imem_req, de_v, ld_de);
    end
    step();
    dep_stall = 1'b0;
    for (int c = 0; c < 20 && !(npop == 4 && seen); c++) begin
      @(negedge clk);
      if (ld_de && npop < 4) begin
        vecs++;
        if (de_npc !== exp_pop + 16'd2 || de_ir !== mem_word(exp_pop)) begin
          miscompares++;
          $display("FAIL drain_pop npc=%h ir=%h exp %h %h", de_npc, de_ir, exp_pop + 16'd2, mem_word(exp_pop));
        end
        exp_pop += 16'd2;
        npop++;
      end
      if (imem_req && !seen) begin
        vecs++;
        if (imem_addr !== 16'h3008) begin
          miscompares++;
          $display("FAIL resume_addr got %h exp 3008", imem_addr);
        end
        seen = 1;
      end
      step();
    end
    vecs++;
    if (npop != 4 || !seen) begin
      miscompares++;
      $display("FAIL drain_timeout pops=%0d seen_req=%0d exp 4 1", npop, seen);
    end
  endtask

  task automatic test_back_to_back();
    int exp_cnt [10];
    logic exp_req [10];
    logic [15:0] exp_pop = 16'h3000;
    exp_cnt = '{4, 3, 2, 2, 1, 1, 0, 1, 0, 1};
    exp_req = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset(1);
    dep_stall = 1'b1;
    fill_queue("b2b");
    step();
    dep_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vecs++;
      if (q_count !== 3'(exp_cnt[i]) || imem_req !== exp_req[i]) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d q=%0d req=%b exp %0d %b", i, q_count, imem_req, exp_cnt[i], exp_req[i]);
      end
      if (ld_de) begin
        vecs++;
        if (de_npc !== exp_pop + 16'd2 || de_ir !== mem_word(exp_pop)) begin
          miscompares++;
          $display("FAIL b2b_pop npc=%h ir=%h exp %h %h", de_npc, de_ir, exp_pop + 16'd2, mem_word(exp_pop));
        end
        exp_pop += 16'd2;
      end
      step();
    end
  endtask

  task automatic test_redirect();
    bit ok = 0;
    bit seen = 0;
    bit got = 0;
    do_reset(3);
    dep_stall = 1'b1;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 16'h3004) ok = 1;
      step();
    end
    vecs++;
    if (!ok) begin
      miscompares++;
      $display("FAIL redir_setup timeout addr=%h exp 3004", imem_addr);
    end
    mem_pcmux = 2'd1;
    target_pc = 16'h4001;
    dep_stall = 1'b0;
    @(negedge clk);
    vecs++;
    if (ld_de !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_ld_de got %b exp 0", ld_de);
    end
    step();
    mem_pcmux = 2'd0;
    @(negedge clk);
    vecs++;
    if (q_count !== 3'd0 || de_v !== 1'b0 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_flush q=%0d de_v=%b req=%b exp 0 0 0", q_count, de_v, imem_req);
    end
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      @(negedge clk);
      if (imem_req && !seen) begin
        vecs++;
        if (imem_addr !== 16'h4000) begin
          miscompares++;
          $display("FAIL redir_addr got %h exp 4000", imem_addr);
        end
        seen = 1;
      end
      if (de_v) begin
        vecs++;
        if (de_npc !== 16'h4002 || de_ir !== mem_word(16'h4000)) begin
          miscompares++;
          $display("FAIL redir_head npc=%h ir=%h exp 4002 %h", de_npc, de_ir, mem_word(16'h4000));
        end
        got = 1;
      end
    end
    vecs++;
    if (!got) begin
      miscompares++;
      $display("FAIL redir_timeout de_v=%b exp 1", de_v);
    end
  endtask

  task automatic test_trap();
    bit ok = 0;
    bit got = 0;
    do_reset(2);
    dep_stall = 1'b1;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (imem_req) ok = 1;
      step();
    end
    vecs++;
    if (!ok) begin
      miscompares++;
      $display("FAIL trap_setup timeout req=%b exp 1", imem_req);
    end
    step();
    mem_pcmux = 2'd2;
    trap_pc = 16'h0200;
    @(negedge clk);
    vecs++;
    if (de_v !== 1'b0 || ld_de !== 1'b0) begin
      miscompares++;
      $display("FAIL trap_cycle de_v=%b ld_de=%b exp 0 0", de_v, ld_de);
    end
    step();
    mem_pcmux = 2'd0;
    @(negedge clk);
    vecs++;
    if (q_count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 16'h0200) begin
      miscompares++;
      $display("FAIL trap_fetch q=%0d req=%b addr=%h exp 0 1 0200", q_count, imem_req, imem_addr);
    end
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      @(negedge clk);
      if (de_v) begin
        vecs++;
        if (de_npc !== 16'h0202 || de_ir !== mem_word(16'h0200)) begin
          miscompares++;
          $display("FAIL trap_head npc=%h ir=%h exp 0202 %h", de_npc, de_ir, mem_word(16'h0200));
        end
        got = 1;
      end
    end
    vecs++;
    if (!got) begin
      miscompares++;
      $display("FAIL trap_timeout de_v=%b exp 1", de_v);
    end
  endtask

  task automatic test_branch_stall();
    bit ok = 0;
    do_reset(1);
    dep_stall = 1'b1;
    fill_queue("brs");
    step();
    v_agex_br_stall = 1'b1;
    dep_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (imem_req !== 1'b0 || q_count !== 3'(4 - i)) begin
        miscompares++;
        $display("FAIL brs_drain%0d req=%b q=%0d exp 0 %0d", i, imem_req, q_count, 4 - i);
      end
      step();
    end
    // Stall raised while a request is outstanding: the response still lands.
    v_agex_br_stall = 1'b0;
    lat = 3;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (imem_req) ok = 1;
      else step();
    end
    vecs++;
    if (!ok || imem_addr !== 16'h3008) begin
      miscompares++;
      $display("FAIL brs_issue req=%b addr=%h exp 1 3008", imem_req, imem_addr);
    end
    step();
    v_agex_br_stall = 1'b1;
    dep_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL brs_noreq%0d req=%b exp 0", i, imem_req);
      end
      step();
    end
    @(negedge clk);
    vecs++;
    if (q_count !== 3'd1 || de_npc !== 16'h300A || de_ir !== mem_word(16'h3008)) begin
      miscompares++;
      $display("FAIL brs_enq q=%0d npc=%h ir=%h exp 1 300a %h", q_count, de_npc, de_ir, mem_word(16'h3008));
    end
    // Reset while a request is outstanding.
    step();
    v_agex_br_stall = 1'b0;
    ok = 0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (imem_req) ok = 1;
      else step();
    end
    vecs++;
    if (!ok || imem_addr !== 16'h300A) begin
      miscompares++;
      $display("FAIL brs_wait_setup req=%b addr=%h exp 1 300a", imem_req, imem_addr);
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    vecs++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h3000 || q_count !== 3'd0 || de_v !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wait req=%b addr=%h q=%0d de_v=%b exp 0 3000 0 0", imem_req, imem_addr, q_count, de_v);
    end
    step();
    @(negedge clk);
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h3000) begin
      miscompares++;
      $display("FAIL rst_refetch req=%b addr=%h exp 1 3000", imem_req, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_redirect();
    test_trap();
    test_branch_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
